// File: rtl/vga_scanout_pkg.sv
// rtl/vga_scanout_pkg.sv - shared 640x480@60 timing constants, framebuffer defaults and pixel types
package vga_scanout_pkg;

  localparam int CNT_W = 10;

  localparam logic [CNT_W-1:0] H_VISIBLE    = 10'd640;
  localparam logic [CNT_W-1:0] H_SYNC_START = 10'd656;
  localparam logic [CNT_W-1:0] H_SYNC_END   = 10'd752;
  localparam logic [CNT_W-1:0] H_LAST       = 10'd799;

  localparam logic [CNT_W-1:0] V_VISIBLE    = 10'd480;
  localparam logic [CNT_W-1:0] V_SYNC_START = 10'd490;
  localparam logic [CNT_W-1:0] V_SYNC_END   = 10'd492;
  localparam logic [CNT_W-1:0] V_LAST       = 10'd524;

  localparam int FB_W_DEF   = 160;
  localparam int FB_H_DEF   = 120;
  localparam int SCALE_DEF  = 4;
  localparam int ADDR_W_DEF = 15;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb332_t;

  // Per-position control bits that travel alongside the pixel fetch.
  typedef struct packed {
    logic visible;
    logic hsync_n;
    logic vsync_n;
    logic vblank;
    logic vblank_start;
  } vga_ctl_t;

  localparam vga_ctl_t CTL_IDLE = '{visible: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                    vblank: 1'b0, vblank_start: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - h/v position counters, raw sync/visible/vblank flags and wrap strobes
module vga_timing
  import vga_scanout_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  output vga_ctl_t ctl_o,
  output logic     v_active_o,
  output logic     line_wrap_o,
  output logic     frame_wrap_o
);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             line_wrap, frame_wrap, v_active;

  always_comb begin
    line_wrap  = (h_cnt_q == H_LAST);
    frame_wrap = line_wrap && (v_cnt_q == V_LAST);
    v_active   = (v_cnt_q < V_VISIBLE);

    h_cnt_d = line_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (frame_wrap) begin
      v_cnt_d = '0;
    end else if (line_wrap) begin
      v_cnt_d = v_cnt_q + 1'b1;
    end

    ctl_o              = CTL_IDLE;
    ctl_o.visible      = (h_cnt_q < H_VISIBLE) && v_active;
    ctl_o.hsync_n      = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
    ctl_o.vsync_n      = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
    ctl_o.vblank       = !v_active;
    ctl_o.vblank_start = (h_cnt_q == '0) && (v_cnt_q == V_VISIBLE);
  end

  assign v_active_o   = v_active;
  assign line_wrap_o  = line_wrap;
  assign frame_wrap_o = frame_wrap;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - framebuffer read engine: replicated address generation, 2-stage pipeline, colour mux
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int FB_W   = FB_W_DEF,
  parameter int FB_H   = FB_H_DEF,
  parameter int SCALE  = SCALE_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              r_clk,
  input  logic              rst_n,
  output logic              fb_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              vblank,
  output logic              vblank_start
);

  localparam int SX_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SX_W-1:0] SX_LAST = SX_W'(SCALE - 1);

  if ((FB_W * SCALE != 640) || (FB_H * SCALE != 480) || ((2 ** ADDR_W) < FB_W * FB_H)) begin : g_bad_geometry
    $error("vga_scanout: framebuffer geometry does not cover 640x480");
  end

  vga_ctl_t ctl0, ctl1_q;
  logic     v_active, line_wrap, frame_wrap;

  vga_timing u_timing (
    .clk_i        (r_clk),
    .rst_ni       (rst_n),
    .ctl_o        (ctl0),
    .v_active_o   (v_active),
    .line_wrap_o  (line_wrap),
    .frame_wrap_o (frame_wrap)
  );

  logic [SX_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic [ADDR_W-1:0] x_idx_q, x_idx_d, row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d, addr_cur;
  rgb332_t           rgb_q, rgb_d;
  logic              hsync_q, vsync_q, vblank_q, vblank_start_q;

  assign addr_cur = row_base_q + x_idx_q;

  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
    x_idx_d     = x_idx_q;
    row_base_d  = row_base_q;
    addr_hold_d = addr_hold_q;

    if (ctl0.visible) begin
      addr_hold_d = addr_cur;
      if (sx_q == SX_LAST) begin
        sx_d    = '0;
        x_idx_d = x_idx_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
      end
    end

    // Rows step only on lines that were actually scanned; the frame wrap rewinds everything.
    if (line_wrap) begin
      sx_d    = '0;
      x_idx_d = '0;
      if (frame_wrap) begin
        sy_d       = '0;
        row_base_d = '0;
      end else if (v_active) begin
        if (sy_q == SX_LAST) begin
          sy_d       = '0;
          row_base_d = row_base_q + ADDR_W'(FB_W);
        end else begin
          sy_d = sy_q + 1'b1;
        end
      end
    end

    rgb_d = ctl1_q.visible ? rgb332_t'(fb_data) : '0;
  end

  // Gated by rst_n so the read port is idle while reset is held, yet live on the first cycle after.
  assign fb_en   = ctl0.visible & rst_n;
  assign fb_addr = ctl0.visible ? addr_cur : addr_hold_q;

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q           <= '0;
      sy_q           <= '0;
      x_idx_q        <= '0;
      row_base_q     <= '0;
      addr_hold_q    <= '0;
      ctl1_q         <= CTL_IDLE;
      rgb_q          <= '0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      vblank_q       <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      sx_q           <= sx_d;
      sy_q           <= sy_d;
      x_idx_q        <= x_idx_d;
      row_base_q     <= row_base_d;
      addr_hold_q    <= addr_hold_d;
      ctl1_q         <= ctl0;
      rgb_q          <= rgb_d;
      hsync_q        <= ctl1_q.hsync_n;
      vsync_q        <= ctl1_q.vsync_n;
      vblank_q       <= ctl1_q.vblank;
      vblank_start_q <= ctl1_q.vblank_start;
    end
  end

  assign red          = rgb_q.red;
  assign green        = rgb_q.green;
  assign blue         = rgb_q.blue;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign vblank       = vblank_q;
  assign vblank_start = vblank_start_q;

endmodule
